// File: rtl/alu_hs_pkg.sv
// Shared encodings for the handshaked ALU.
// These are also used by the sequence and parameter packages,
// so those packages and this RTL use the same opcode values.
package alu_hs_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_SHL  = 4'd3,
        OP_SHR  = 4'd4,
        OP_ROL  = 4'd5,
        OP_ROR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NAND = 4'd11,
        OP_NOR  = 4'd12,
        OP_XNOR = 4'd13,
        OP_INC  = 4'd14,
        OP_DEC  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        MOVI_REG_B = 2'd0,
        MOVI_MEM   = 2'd1,
        MOVI_IMM   = 2'd2,
        MOVI_RSVD  = 2'd3
    } movi_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Reference values for the default 8-bit build.
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_MUL_CYCLES = DEFAULT_DATA_WIDTH;
    localparam int OP_WIDTH           = 4;
    localparam int MOVI_WIDTH         = 2;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per step.
// The load input captures the operands, and the counter then runs from DATA_WIDTH-1 down to 0.
// The product output already contains the current step's addition.
// When done is high, the product output is the final product.
module alu_mul_seq
    import alu_hs_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);
    localparam int CW = $clog2(DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [CW-1:0]           cnt;

    assign product = prod + (mplier[0] ? mcand : '0);
    assign done    = (cnt == '0);

    // Operand capture on load, then one shift-add per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{DATA_WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
            cnt    <= CW'(DATA_WIDTH - 1);
        end else if (step) begin
            prod   <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_hs_core.sv
// This is the handshaked ALU core.
// It contains the operand-B mux, the single-cycle ALU, the FSM and the output register, which supports backpressure.
// The ALU_MUL_EN macro enables the iterative multiplier. Without it, OP 2 returns 0 in one cycle.
module alu_hs_core
    import alu_hs_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ACT,
    output logic                  ALU_RDY,
    input  logic [3:0]            OP,
    input  logic [1:0]            MOVI,
    input  logic [DATA_WIDTH-1:0] REG_A,
    input  logic [DATA_WIDTH-1:0] REG_B,
    input  logic [DATA_WIDTH-1:0] MEM,
    input  logic [DATA_WIDTH-1:0] IMM,
    output logic [DATA_WIDTH-1:0] EX_ALU,
    output logic                  EX_CARRY,
    output logic                  EX_ZERO,
    output logic                  EX_ALU_VLD,
    input  logic                  OUT_RDY
);
    localparam int W = DATA_WIDTH;

    state_t        state;
    alu_op_t       op;
    logic [W-1:0]  a, b, res;
    logic          cy, xfer, is_mul;
    logic          wr_en, wr_cy;
    logic [W-1:0]  wr_res;

    assign op      = alu_op_t'(OP);
    assign a       = REG_A;
    assign is_mul  = (op == OP_MUL);
    // Accept only when idle and when the output register is free or is being drained in this cycle.
    assign ALU_RDY = !RST && (state == IDLE) && (!EX_ALU_VLD || OUT_RDY);
    assign xfer    = ACT && ALU_RDY;

    // Operand B source select; the reserved code reads as zero.
    always_comb begin
        b = '0;
        case (movi_t'(MOVI))
            MOVI_REG_B: b = REG_B;
            MOVI_MEM:   b = MEM;
            MOVI_IMM:   b = IMM;
            default:    b = '0;
        endcase
    end

    // Single-cycle datapath; the MUL branch yields 0 in this path.
    always_comb begin
        res = '0;
        cy  = 1'b0;
        case (op)
            OP_ADD:  {cy, res} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {cy, res} = {1'b0, a} - {1'b0, b};
            OP_MUL:  begin res = '0; cy = 1'b0; end
            OP_SHL:  begin res = {a[W-2:0], 1'b0};   cy = a[W-1]; end
            OP_SHR:  begin res = {1'b0, a[W-1:1]};   cy = a[0];   end
            OP_ROL:  begin res = {a[W-2:0], a[W-1]}; cy = a[W-1]; end
            OP_ROR:  begin res = {a[0], a[W-1:1]};   cy = a[0];   end
            OP_NOT:  res = ~a;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_XNOR: res = ~(a ^ b);
            OP_INC:  {cy, res} = {1'b0, a} + {{W{1'b0}}, 1'b1};
            OP_DEC:  {cy, res} = {1'b0, a} - {{W{1'b0}}, 1'b1};
            default: begin res = '0; cy = 1'b0; end
        endcase
    end

`ifdef ALU_MUL_EN
    logic               mul_done;
    logic [2*W-1:0]     mul_prod;

    alu_mul_seq #(.DATA_WIDTH(W)) u_mul (
        .clk     (CLK),
        .rst     (RST),
        .load    (xfer && is_mul),
        .step    (state == MUL),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // A result is written by a non-MUL transfer or by the final multiply step.
    always_comb begin
        wr_en  = 1'b0;
        wr_res = res;
        wr_cy  = cy;
        if (state == MUL) begin
            wr_en  = mul_done;
            wr_res = mul_prod[W-1:0];
            wr_cy  = |mul_prod[2*W-1:W];
        end else if (xfer && !is_mul) begin
            wr_en  = 1'b1;
        end
    end
`else
    // Every transfer writes a result in the next cycle; OP 2 falls out of the datapath as 0.
    always_comb begin
        wr_en  = xfer;
        wr_res = res;
        wr_cy  = cy;
    end
`endif

    // Control FSM and output register; a new write takes priority over the clear on consumption.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            EX_ALU     <= '0;
            EX_CARRY   <= 1'b0;
            EX_ZERO    <= 1'b0;
            EX_ALU_VLD <= 1'b0;
        end else begin
            if (EX_ALU_VLD && OUT_RDY)
                EX_ALU_VLD <= 1'b0;
            if (wr_en) begin
                EX_ALU     <= wr_res;
                EX_CARRY   <= wr_cy;
                EX_ZERO    <= (wr_res == '0);
                EX_ALU_VLD <= 1'b1;
            end
            case (state)
`ifdef ALU_MUL_EN
                IDLE:    if (xfer && is_mul) state <= MUL;
                MUL:     if (mul_done) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_hs_core.sv
// Scoreboard bench for alu_hs_core, using random and directed stimulus.
// Each transfer pushes its expected result.
// The negedge monitor compares the displayed result and pops it on consumption.
module tb_alu_hs_core;
    localparam int W = 8;
    localparam longint unsigned MODV = 64'd1 << W;
    localparam longint unsigned MASK = MODV - 1;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         ACT = 1'b0;
    logic         ALU_RDY;
    logic [3:0]   OP = '0;
    logic [1:0]   MOVI = '0;
    logic [W-1:0] REG_A = '0, REG_B = '0, MEM = '0, IMM = '0;
    logic [W-1:0] EX_ALU;
    logic         EX_CARRY, EX_ZERO, EX_ALU_VLD;
    logic         OUT_RDY = 1'b1;

    int   checks = 0, failures = 0;
    exp_t q[$];
    bit   m_vld = 0;
    int   m_left = 0;
    int   xfers = 0;
    bit   rnd_on = 0;
    bit   m_rdy;

    alu_hs_core #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .ACT(ACT), .ALU_RDY(ALU_RDY), .OP(OP), .MOVI(MOVI),
        .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM),
        .EX_ALU(EX_ALU), .EX_CARRY(EX_CARRY), .EX_ZERO(EX_ZERO),
        .EX_ALU_VLD(EX_ALU_VLD), .OUT_RDY(OUT_RDY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU using plain modular arithmetic.
    function automatic exp_t ref_alu(input int op, input longint unsigned a, input longint unsigned b);
        longint unsigned r = 0, c = 0, p;
        exp_t e;
        case (op)
            0:  begin r = (a + b) % MODV; c = (a + b >= MODV); end
            1:  begin r = (a + MODV - b) % MODV; c = (a < b); end
            2:  if (MUL_EN) begin p = a * b; r = p % MODV; c = (p / MODV != 0); end
            3:  begin r = (a * 2) % MODV; c = (a >= MODV / 2); end
            4:  begin r = a / 2; c = a % 2; end
            5:  begin r = (a * 2) % MODV + (a >= MODV / 2 ? 1 : 0); c = (a >= MODV / 2); end
            6:  begin r = a / 2 + (a % 2) * (MODV / 2); c = a % 2; end
            7:  r = MASK - a;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = MASK - (a & b);
            12: r = MASK - (a | b);
            13: r = MASK - (a ^ b);
            14: begin r = (a + 1) % MODV; c = (a == MASK); end
            default: begin r = (a + MODV - 1) % MODV; c = (a == 0); end
        endcase
        e.res = W'(r);
        e.c   = c[0];
        e.z   = (r == 0);
        return e;
    endfunction

    // Transaction-level model of the handshake, occupancy and multiply latency.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            q.delete();
            m_vld  = 0;
            m_left = 0;
        end else begin
            longint unsigned bsel;
            m_rdy = (m_left == 0) && (!m_vld || OUT_RDY);
            if (m_vld && OUT_RDY) m_vld = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_vld = 1;
            end
            if (ACT && m_rdy) begin
                bsel = (MOVI == 0) ? REG_B : (MOVI == 1) ? MEM : (MOVI == 2) ? IMM : 0;
                q.push_back(ref_alu(OP, REG_A, bsel));
                xfers++;
                if (OP == 2 && MUL_EN) m_left = W;
                else m_vld = 1;
            end
        end
    end

    // Monitor: check handshake and reset values, then compare the displayed result and pop it on consumption.
    always @(negedge CLK) begin
        chk("alu_rdy", ALU_RDY, !RST && m_left == 0 && (!m_vld || OUT_RDY));
        chk("ex_alu_vld", EX_ALU_VLD, m_vld);
        if (RST) begin
            chk("rst_ex_alu", EX_ALU, 0);
            chk("rst_ex_carry", EX_CARRY, 0);
            chk("rst_ex_zero", EX_ZERO, 0);
        end else if (m_vld) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                chk("ex_alu", EX_ALU, q[0].res);
                chk("ex_carry", EX_CARRY, q[0].c);
                chk("ex_zero", EX_ZERO, q[0].z);
                if (OUT_RDY) void'(q.pop_front());
            end
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge CLK) begin
        if (rnd_on) begin
            #1;
            OUT_RDY = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one operation and hold ACT until the model sees a transfer; scramble operands afterwards.
    task automatic issue(input int op, input int mv, input int a, input int b, input int m, input int i,
                         output int waited);
        int n0 = xfers;
        OP = 4'(op); MOVI = 2'(mv); REG_A = W'(a); REG_B = W'(b); MEM = W'(m); IMM = W'(i);
        ACT = 1'b1;
        waited = 0;
        while (xfers == n0 && waited < 200) begin
            @(posedge CLK); #1;
            waited++;
        end
        if (xfers == n0) chk("transfer_timeout", 0, 1);
        ACT = 1'b0;
        REG_A = W'($urandom); REG_B = W'($urandom); MEM = W'($urandom); IMM = W'($urandom);
        MOVI = 2'($urandom);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    initial begin
        int w;
        cycles(3);
        RST = 1'b0;
        cycles(1);

        issue(0, 0, 'hFF, 'h01, 0, 0, w);
        chk("add_latency", w, 1);
        issue(1, 2, 'h05, 0, 0, 'h07, w);
        issue(1, 3, 'h05, 'h33, 'h44, 'h55, w);
        issue(2, 0, 'h0F, 'h11, 0, 0, w);
        issue(2, 1, 'h10, 0, 'h10, 0, w);
        issue(5, 0, 'h81, 0, 0, 0, w);

        // Stall: hold OUT_RDY low for 5 cycles while XOR waits.
        OUT_RDY = 1'b0;
        fork
            begin cycles(5); OUT_RDY = 1'b1; end
        join_none
        issue(10, 0, 'h5A, 'h3C, 0, 0, w);
        chk("stall_accept_cycle", w, 6);
        cycles(2);

        // Reset three cycles into a multiply.
        issue(2, 0, 'h0F, 'h11, 0, 0, w);
        cycles(3);
        RST = 1'b1;
        cycles(1);
        RST = 1'b0;
        issue(0, 0, 'h02, 'h03, 0, 0, w);
        chk("post_reset_add_latency", w, 1);
        cycles(2);

        // Random operations with random backpressure and idle gaps.
        rnd_on = 1;
        for (int k = 0; k < 250; k++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom, w);
            cycles($urandom_range(0, 2));
        end
        rnd_on = 0;
        cycles(1);
        OUT_RDY = 1'b1;
        cycles(20);
        chk("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_hs_core.md
# alu_hs_core

Parametrised, handshaked successor of the HAVEN ALU DUT and the next RTL target for the GA-driven UVM environment. It accepts one operation per transfer through a valid/ready input handshake and selects operand B from register, memory or immediate. Single-cycle operations complete in one cycle; an iterative shift-add multiplier takes DATA_WIDTH cycles. Results are held in an output register with backpressure.

## Interface
- DATA_WIDTH, 8: operand and result width; legal range 4..64.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ACT  in  1  input valid.
- ALU_RDY  out  1  input ready; a transfer occurs when ACT && ALU_RDY.
- OP  in  4  operation code.
- MOVI  in  2  operand B select: 0 REG_B, 1 MEM, 2 IMM, 3 reserved (B = 0).
- REG_A, REG_B, MEM, IMM  in  DATA_WIDTH each  operands.
- EX_ALU  out  DATA_WIDTH  result.
- EX_CARRY  out  1  carry/borrow/shifted-out bit.
- EX_ZERO  out  1  result == 0.
- EX_ALU_VLD  out  1  result valid.
- OUT_RDY  in  1  consumer ready; the result is consumed when EX_ALU_VLD && OUT_RDY.

## Operation
- OP codes:
  - 0 ADD, 1 SUB (A-B), 2 MUL (low DATA_WIDTH bits), 3 SHL, 4 SHR, 5 ROL, 6 ROR, 7 NOT A.
  - 8 AND, 9 OR, 10 XOR, 11 NAND, 12 NOR, 13 XNOR, 14 INC A, 15 DEC A.
- Carry rules:
  - ADD/INC: carry-out. SUB/DEC: borrow.
  - SHL/ROL: old A MSB. SHR/ROR: old A LSB.
  - MUL: OR of the discarded high product bits. Logic ops: 0.
- All arithmetic is modulo 2^DATA_WIDTH. Operands are latched at the transfer; later input changes have no effect.
- FSM states:
  - IDLE:
    - Non-MUL transfer: the result is written to the output register and the state stays IDLE.
    - MUL transfer: go to MUL, load multiplicand, multiplier and product = 0, counter = DATA_WIDTH-1.
  - MUL: one shift-add step per cycle. When counter == 0, write the result to the output register, then go to IDLE.
- ALU_RDY = (state == IDLE) && (!EX_ALU_VLD || OUT_RDY). Input is accepted in the same cycle a result is consumed, giving full throughput.
- EX_ALU_VLD is set when a result is written. It clears on consumption unless a new result is written in the same cycle.
- EX_ALU, EX_CARRY and EX_ZERO are stable while EX_ALU_VLD && !OUT_RDY.
- Reset values: state IDLE, EX_ALU 0, EX_CARRY 0, EX_ZERO 0, EX_ALU_VLD 0, ALU_RDY 0 during RST, 1 the first cycle after.
- Reset mid-MUL aborts the operation: no result is produced and the state returns to IDLE.

## Timing
- Non-MUL: transfer at edge t, result and EX_ALU_VLD visible after edge t (latency 1).
- MUL: transfer at edge t, EX_ALU_VLD after edge t+DATA_WIDTH. ALU_RDY is low from edge t through the result-write edge.
- Back-to-back non-MUL ops with OUT_RDY held high: one result per cycle.
- OUT_RDY low with EX_ALU_VLD high forces ALU_RDY low, so ACT is ignored and no transfer occurs.
- A MUL completing while the previous result is still unconsumed cannot happen: MUL is only accepted when the output register will be free.

## Configuration
- ALU_MUL_EN defined:
  - MUL state, multiplier datapath and counter are present.
  - Behaviour as above.
- ALU_MUL_EN undefined:
  - No MUL state.
  - OP 2 completes in one cycle with EX_ALU = 0, EX_CARRY = 0, EX_ZERO = 1.

## Structure
- Shared package alu_hs_pkg:
  - enum alu_op_t (16 codes above), enum movi_t, enum state_t {IDLE, MUL}.
  - localparam reference values for the default width.
  - Shared with the sv_alu param/sequence packages so the GA generator uses the same encodings.
- Sub-module alu_mul_seq holds the iterative multiplier: load/step/done interface with counter and product registers. It is instantiated only under ALU_MUL_EN.
- The top level holds the handshake, operand mux, combinational single-cycle ALU, FSM and output register.

## Test plan
- ADD, REG_A=0xFF, MOVI=0, REG_B=0x01, OUT_RDY=1 → one cycle later EX_ALU=0x00, EX_CARRY=1, EX_ZERO=1, EX_ALU_VLD=1.
- SUB, REG_A=0x05, MOVI=2, IMM=0x07 → EX_ALU=0xFE, EX_CARRY=1. MOVI=3 with the same A → EX_ALU=0x05, EX_CARRY=0.
- MUL 0x0F×0x11 → ALU_RDY low 8 cycles, EX_ALU=0xFF, EX_CARRY=0. MUL 0x10×0x10 → 0x00, EX_CARRY=1, EX_ZERO=1.
- ROL 0x81 → 0x03 carry 1. Then OUT_RDY=0 for 5 cycles with ACT=1, XOR pending → EX_ALU holds 0x03, ALU_RDY=0, no transfer. Raising OUT_RDY → XOR accepted the same cycle.
- RST asserted 3 cycles into a MUL → EX_ALU_VLD=0, EX_ALU=0. Next ADD 0x02+0x03 → 0x05 with latency 1.
- Build without ALU_MUL_EN, OP=2 with A=0x0F, B=0x11 → EX_ALU=0, EX_ZERO=1, latency 1.
